// File: rtl/ysyx_20020207_pkg.sv
// Shared encodings for the ysyx_20020207 core: memory-op and access-size codes,
// the LSU state enum and the AXI response constant.
package ysyx_20020207_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B,
        S_DONE
    } lsu_state_e;

endpackage

// File: rtl/ysyx_20020207_lsu_if.sv
// AXI4-Lite data port between the LSU (master) and the memory subsystem (slave).
interface ysyx_20020207_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_20020207_lsu_align.sv
// Combinational data alignment: store lane replication/strobes and misalignment
// detect for the incoming request, lane select and extension for returned load data.
module ysyx_20020207_lsu_align
    import ysyx_20020207_pkg::*;
(
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] load_data_o
);

    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    always_comb begin
        wdata_o      = store_data_i;
        wstrb_o      = 4'b1111;
        misaligned_o = 1'b0;
        case (req_funct3_i)
            F3_B, F3_BU: begin
                wdata_o = {4{store_data_i[7:0]}};
                wstrb_o = 4'b0001 << req_addr_lo_i;
            end
            F3_H, F3_HU: begin
                wdata_o      = {2{store_data_i[15:0]}};
                wstrb_o      = 4'b0011 << req_addr_lo_i;
                misaligned_o = req_addr_lo_i[0];
            end
            default: misaligned_o = (req_addr_lo_i != 2'b00);
        endcase
    end

    // Halfword accesses are aligned, so addr[1] alone picks the half lane.
    assign ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign ld_byte = ld_addr_lo_i[0] ? ld_half[15:8] : ld_half[7:0];

    always_comb begin
        load_data_o = rdata_i;
        case (ld_funct3_i)
            F3_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data_o = {24'd0, ld_byte};
            F3_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data_o = {16'd0, ld_half};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: accepts one instruction from execute, performs at most one
// AXI4-Lite access and produces the write-back value with a one-cycle finish strobe.
module ysyx_20020207_lsu
    import ysyx_20020207_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mem_op,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  lsu_finish,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  fault,
    ysyx_20020207_lsu_if.master   axi
);

    lsu_state_e              state_q;
    logic                    in_ready_q, finish_q, fault_q;
    logic [2:0]              f3_q;
    logic [1:0]              alo_q;
    logic [DATA_WIDTH-1:0]   wb_data_q, wdata_q;
    logic [ADDR_WIDTH-1:0]   araddr_q, awaddr_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

    logic [DATA_WIDTH-1:0]   wdata_d, load_data_d;
    logic [DATA_WIDTH/8-1:0] wstrb_d;
    logic                    misaligned_d, is_mem_d, aw_done_d, w_done_d;
    logic [ADDR_WIDTH-1:0]   word_addr_d;

    ysyx_20020207_lsu_align u_align (
        .req_funct3_i  (funct3),
        .req_addr_lo_i (addr[1:0]),
        .store_data_i  (store_data),
        .wdata_o       (wdata_d),
        .wstrb_o       (wstrb_d),
        .misaligned_o  (misaligned_d),
        .ld_funct3_i   (f3_q),
        .ld_addr_lo_i  (alo_q),
        .rdata_i       (axi.rdata),
        .load_data_o   (load_data_d)
    );

    assign is_mem_d    = (mem_op == MEM_LOAD) || (mem_op == MEM_STORE);
    assign word_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
    // Each write channel is done once accepted earlier or accepted this cycle.
    assign aw_done_d   = !awvalid_q || axi.awready;
    assign w_done_d    = !wvalid_q || axi.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            finish_q   <= 1'b0;
            fault_q    <= 1'b0;
            wb_data_q  <= '0;
            f3_q       <= '0;
            alo_q      <= '0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        f3_q       <= funct3;
                        alo_q      <= addr[1:0];
                        in_ready_q <= 1'b0;
                        if (is_mem_d && misaligned_d) begin
                            state_q   <= S_DONE;
                            finish_q  <= 1'b1;
                            fault_q   <= 1'b1;
                            wb_data_q <= '0;
                        end else if (mem_op == MEM_LOAD) begin
                            state_q   <= S_AR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= word_addr_d;
                        end else if (mem_op == MEM_STORE) begin
                            state_q   <= S_WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= word_addr_d;
                            wdata_q   <= wdata_d;
                            wstrb_q   <= wstrb_d;
                        end else begin
                            state_q   <= S_DONE;
                            finish_q  <= 1'b1;
                            fault_q   <= 1'b0;
                            wb_data_q <= alu_result;
                        end
                    end
                end
                S_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (axi.rvalid) begin
                        rready_q  <= 1'b0;
                        wb_data_q <= load_data_d;
                        fault_q   <= (axi.rresp != RESP_OKAY);
                        finish_q  <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_WR: begin
                    if (axi.awready) awvalid_q <= 1'b0;
                    if (axi.wready)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_B;
                    end
                end
                S_B: begin
                    if (axi.bvalid) begin
                        bready_q  <= 1'b0;
                        wb_data_q <= '0;
                        fault_q   <= (axi.bresp != RESP_OKAY);
                        finish_q  <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    finish_q   <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    finish_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign lsu_finish  = finish_q;
    assign wb_data     = wb_data_q;
    assign fault       = fault_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// Bench for ysyx_20020207_lsu: directed and random transactions against a
// cycle-counting AXI slave and an arithmetic reference of the load/store rules.
module tb_ysyx_20020207_lsu;
    import ysyx_20020207_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  mem_op;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, alu_result, wb_data;
    logic        lsu_finish, fault;

    ysyx_20020207_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    ysyx_20020207_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_op     (mem_op),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .alu_result (alu_result),
        .lsu_finish (lsu_finish),
        .wb_data    (wb_data),
        .fault      (fault),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lo, input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * lo);
        case (f3)
            3'b000:  return 32'($signed(v[7:0]));
            3'b100:  return v & 32'h0000_00FF;
            3'b001:  return 32'($signed(v[15:0]));
            3'b101:  return v & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz;
        sz = size_of(f3);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_wstrb(input logic [2:0] f3, input int lo);
        int sz;
        logic [31:0] s;
        sz = size_of(f3);
        s  = 0;
        for (int i = 0; i < 4; i++)
            if (sz == 4 || (i >= lo && i < lo + sz)) s = s + (32'd1 << i);
        return s;
    endfunction

    task automatic slave_idle();
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    endtask

    task automatic run_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                           input logic [31:0] mword, input logic [1:0] resp,
                           input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d);
        int lo, cyc, exp_lat;
        int ar_w, r_w, aw_w, w_w, b_w;
        logic is_ld, is_st, mis, bus, done;
        logic ar_acc, r_acc, aw_acc, w_acc, b_acc;
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic [31:0] exp_wb;
        logic exp_fault;
        lo = int'(a % 4);
        is_ld = (op == 2'b01);
        is_st = (op == 2'b10);
        mis = (is_ld || is_st) && ((lo % size_of(f3)) != 0);
        bus = (is_ld || is_st) && !mis;
        ar_w = ar_d; r_w = r_d; aw_w = aw_d; w_w = w_d; b_w = b_d;
        if (mis) begin
            exp_wb = 0; exp_fault = 1; exp_lat = 1;
        end else if (is_ld) begin
            exp_wb = ref_load(f3, lo, mword); exp_fault = (resp != 0); exp_lat = 3 + ar_d + r_d;
        end else if (is_st) begin
            exp_wb = 0; exp_fault = (resp != 0); exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
        end else begin
            exp_wb = alu; exp_fault = 0; exp_lat = 1;
        end
        expect_eq({tag, ".accept_ready"}, 32'(in_ready), 1);
        in_valid = 1; mem_op = op; funct3 = f3; addr = a; store_data = sd; alu_result = alu;
        @(posedge clk); #1;
        in_valid = 0; mem_op = 2'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom; alu_result = $urandom;
        ar_acc = 0; r_acc = 0; aw_acc = 0; w_acc = 0; b_acc = 0;
        done = 0; cyc = 1;
        while (!done && cyc <= 200) begin
            if (!bus) expect_eq({tag, ".nobus"}, 32'({axi.arvalid, axi.awvalid, axi.wvalid}), 0);
            if (lsu_finish) begin
                expect_eq({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
                expect_eq({tag, ".wb_data"}, wb_data, exp_wb);
                expect_eq({tag, ".fault"}, 32'(fault), 32'(exp_fault));
                expect_eq({tag, ".done_busy"}, 32'(in_ready), 0);
                expect_eq({tag, ".done_idle_bus"},
                          32'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 0);
                slave_idle();
                done = 1;
            end else begin
                expect_eq({tag, ".busy"}, 32'(in_ready), 0);
                expect_eq({tag, ".arvalid"}, 32'(axi.arvalid), 32'(bus && is_ld && !ar_acc));
                expect_eq({tag, ".rready"},  32'(axi.rready),  32'(bus && is_ld && ar_acc && !r_acc));
                expect_eq({tag, ".awvalid"}, 32'(axi.awvalid), 32'(bus && is_st && !aw_acc));
                expect_eq({tag, ".wvalid"},  32'(axi.wvalid),  32'(bus && is_st && !w_acc));
                expect_eq({tag, ".bready"},  32'(axi.bready),  32'(bus && is_st && aw_acc && w_acc && !b_acc));
                axi.arready = 0;
                if (axi.arvalid) begin
                    expect_eq({tag, ".araddr"}, axi.araddr, a & 32'hFFFF_FFFC);
                    if (ar_w == 0) axi.arready = 1; else ar_w--;
                end
                axi.rvalid = 0;
                if (ar_acc && !r_acc) begin
                    if (r_w == 0) begin axi.rvalid = 1; axi.rdata = mword; axi.rresp = resp; end
                    else begin r_w--; axi.rdata = $urandom; end
                end
                axi.awready = 0;
                if (axi.awvalid) begin
                    expect_eq({tag, ".awaddr"}, axi.awaddr, a & 32'hFFFF_FFFC);
                    if (aw_w == 0) axi.awready = 1; else aw_w--;
                end
                axi.wready = 0;
                if (axi.wvalid) begin
                    expect_eq({tag, ".wdata"}, axi.wdata, ref_wdata(f3, sd));
                    expect_eq({tag, ".wstrb"}, 32'(axi.wstrb), ref_wstrb(f3, lo));
                    if (w_w == 0) axi.wready = 1; else w_w--;
                end
                axi.bvalid = 0;
                if (aw_acc && w_acc && !b_acc) begin
                    if (b_w == 0) begin axi.bvalid = 1; axi.bresp = resp; end
                    else b_w--;
                end
                ar_hs = axi.arvalid && axi.arready;
                r_hs  = axi.rvalid && axi.rready;
                aw_hs = axi.awvalid && axi.awready;
                w_hs  = axi.wvalid && axi.wready;
                b_hs  = axi.bvalid && axi.bready;
                @(posedge clk); #1;
                cyc++;
                if (ar_hs) ar_acc = 1;
                if (r_hs)  r_acc = 1;
                if (aw_hs) aw_acc = 1;
                if (w_hs)  w_acc = 1;
                if (b_hs)  b_acc = 1;
            end
        end
        if (!done) begin
            expect_eq({tag, ".timeout"}, 0, 1);
            slave_idle();
        end
        @(posedge clk); #1;
        expect_eq({tag, ".strobe_once"}, 32'(lsu_finish), 0);
        expect_eq({tag, ".ready_after"}, 32'(in_ready), 1);
        expect_eq({tag, ".wb_hold"}, wb_data, exp_wb);
        expect_eq({tag, ".fault_hold"}, 32'(fault), 32'(exp_fault));
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1; in_valid = 0; mem_op = 0; funct3 = 0; addr = 0; store_data = 0; alu_result = 0;
        slave_idle(); axi.rdata = 0; axi.rresp = 0; axi.bresp = 0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst.in_ready", 32'(in_ready), 1);
        expect_eq("rst.finish", 32'(lsu_finish), 0);
        expect_eq("rst.fault", 32'(fault), 0);
        expect_eq("rst.wb_data", wb_data, 0);
        expect_eq("rst.valids", 32'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 0);
        expect_eq("rst.araddr", axi.araddr, 0);
        expect_eq("rst.awaddr", axi.awaddr, 0);
        expect_eq("rst.wdata", axi.wdata, 0);
        expect_eq("rst.wstrb", 32'(axi.wstrb), 0);
        rst = 0;

        run_txn("none", 2'b00, 3'b010, 32'h0000_0040, 32'h0, 32'h1234_5678, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        run_txn("lb", 2'b01, 3'b000, 32'h8000_0003, 32'h0, 32'h0, 32'h80FF_0000, 2'b00, 0, 0, 0, 0, 0);
        expect_eq("lb.value", wb_data, 32'hFFFF_FF80);
        run_txn("lbu", 2'b01, 3'b100, 32'h8000_0003, 32'h0, 32'h0, 32'h80FF_0000, 2'b00, 0, 0, 0, 0, 0);
        expect_eq("lbu.value", wb_data, 32'h0000_0080);
        run_txn("sh", 2'b10, 3'b001, 32'h8000_0002, 32'hAAAA_BEEF, 32'h0, 32'h0, 2'b00, 0, 0, 2, 0, 0);
        run_txn("sw0", 2'b10, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        run_txn("lw_mis", 2'b01, 3'b010, 32'h8000_0002, 32'h0, 32'h5555_5555, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        expect_eq("lw_mis.fault", 32'(fault), 1);
        run_txn("lw_slverr", 2'b01, 3'b010, 32'h8000_0004, 32'h0, 32'h0, 32'h1111_2222, 2'b10, 0, 0, 0, 0, 0);
        expect_eq("lw_slverr.fault", 32'(fault), 1);
        run_txn("ar_stall", 2'b01, 3'b101, 32'h8000_0012, 32'h0, 32'h0, 32'h9876_5432, 2'b00, 5, 0, 0, 0, 0);
        run_txn("op11", 2'b11, 3'b000, 32'h8000_0001, 32'h0, 32'hDEAD_BEEF, 32'h0, 2'b00, 0, 0, 0, 0, 0);

        // Reset while the load waits in the read-data phase.
        in_valid = 1; mem_op = 2'b01; funct3 = 3'b010; addr = 32'h8000_0010;
        @(posedge clk); #1;
        in_valid = 0;
        axi.arready = 1;
        @(posedge clk); #1;
        axi.arready = 0;
        expect_eq("mrst.in_r", 32'(axi.rready), 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        expect_eq("mrst.rready", 32'(axi.rready), 0);
        expect_eq("mrst.in_ready", 32'(in_ready), 1);
        expect_eq("mrst.arvalid", 32'(axi.arvalid), 0);
        for (int i = 0; i < 5; i++) begin
            expect_eq("mrst.no_finish", 32'(lsu_finish), 0);
            @(posedge clk); #1;
        end
        run_txn("post_rst", 2'b01, 3'b001, 32'h8000_0016, 32'h0, 32'h0, 32'h8001_7FFF, 2'b00, 1, 1, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0]  op;
            logic [2:0]  f3;
            logic [1:0]  rs;
            op = 2'($urandom_range(0, 3));
            f3 = f3_tab[$urandom_range(0, 4)];
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn("rand", op, f3, $urandom, $urandom, $urandom, $urandom, rs,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
